// File: rtl/filter_pair_fifo.sv
// filter_pair_fifo
//   Packs consecutive (even, odd) filter samples into one 2*DATA_W word,
//   buffers the words in a DEPTH-entry FIFO and drains them through a
//   valid/ready handshake (first-word-fall-through). A completed pair that
//   finds the FIFO full and no simultaneous pop is dropped and latches a
//   sticky overflow flag that only reset clears.
module filter_pair_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [2*DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // LO: waiting for the even (low) sample; HI: low half captured, waiting for odd.
  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } pair_state_e;

  pair_state_e          state_q, state_d;
  logic [DATA_W-1:0]    lo_q, lo_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, out_valid_d;

  logic                 pop_s;
  logic                 push_try_s;
  logic                 push_ok_s;
  logic [2*DATA_W-1:0]  wr_word_s;

  // Word storage; contents are intentionally left unreset.
  logic [2*DATA_W-1:0]  mem_q [DEPTH];

  // Pairing FSM, push/pop arbitration and next-state for pointers, count and flags.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    push_try_s  = 1'b0;
    push_ok_s   = 1'b0;
    pop_s       = 1'b0;
    wr_word_s   = {in_data, lo_q};

    if (flush) begin
      // Flush discards buffered words and this cycle's sample; overflow survives.
      state_d  = ST_LO;
      wr_ptr_d = {ADDR_W{1'b0}};
      rd_ptr_d = {ADDR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      pop_s = out_valid_q & out_ready;

      case (state_q)
        ST_LO: begin
          if (in_valid) begin
            lo_d    = in_data;
            state_d = ST_HI;
          end else begin
            state_d = ST_LO;
          end
        end
        ST_HI: begin
          if (in_valid) begin
            push_try_s = 1'b1;
            state_d    = ST_LO;
          end else begin
            state_d = ST_HI;
          end
        end
        default: begin
          state_d = ST_LO;
        end
      endcase

      // A full FIFO still accepts the word when the head leaves in the same cycle.
      push_ok_s = push_try_s & ((count_q < DEPTH_C) | pop_s);

      if (push_try_s && !push_ok_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    out_valid_d = (count_d != {CNT_W{1'b0}});
  end

  // Control state register with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LO;
      lo_q        <= {DATA_W{1'b0}};
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Write an accepted packed word into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_word_s;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_filter_pair_fifo.sv
// Bench for filter_pair_fifo: a queue-based model of the pair/FIFO behaviour
// is stepped every clock and compared against the DUT on every falling edge,
// with directed scenarios pinning literal values and a randomized stream.
module tb_filter_pair_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 flush;
  logic                 out_ready;
  logic                 out_valid;
  logic [2*DATA_W-1:0]  out_data;
  logic [3:0]           level;
  logic                 overflow;

  filter_pair_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [63:0]  m_q[$];
  bit           m_have_lo;
  logic [31:0]  m_lo;
  bit           m_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock of the specified behaviour to the model.
  function automatic void model_step(input bit r, input bit f, input bit iv,
                                     input logic [31:0] d, input bit rdy);
    bit popped;
    if (r) begin
      m_q.delete();
      m_have_lo = 1'b0;
      m_ovf     = 1'b0;
    end else if (f) begin
      m_q.delete();
      m_have_lo = 1'b0;
    end else begin
      popped = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (iv) begin
        if (!m_have_lo) begin
          m_lo      = d;
          m_have_lo = 1'b1;
        end else begin
          m_have_lo = 1'b0;
          if (m_q.size() < DEPTH) m_q.push_back({d, m_lo});
          else m_ovf = 1'b1;
        end
      end
    end
  endfunction

  task automatic cycle(input bit r, input bit f, input bit iv,
                       input logic [31:0] d, input bit rdy);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_step(r, f, iv, d, rdy);
    @(negedge clk);
  endtask

  task automatic sample(input logic [31:0] d, input bit rdy);
    cycle(1'b0, 1'b0, 1'b1, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {63'h0, out_valid}, {63'h0, (m_q.size() != 0)});
      chk("level", {60'h0, level}, 64'(m_q.size()));
      chk("overflow", {63'h0, overflow}, {63'h0, m_ovf});
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    end
  end

  initial begin
    logic [63:0] e;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;

    // 1: reset, then one pair
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_level", {60'h0, level}, 64'h0);
    sample(32'h11, 1'b0);
    sample(32'h22, 1'b0);
    chk("t1_valid", {63'h0, out_valid}, 64'h1);
    chk("t1_data", out_data, 64'h00000022_00000011);
    chk("t1_level", {60'h0, level}, 64'h1);

    // 2: fill, overflow, drain in order
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 16; i++) sample(32'(i), 1'b0);
    chk("t2_full_level", {60'h0, level}, 64'h8);
    chk("t2_no_ovf", {63'h0, overflow}, 64'h0);
    sample(32'd17, 1'b0);
    sample(32'd18, 1'b0);
    chk("t2_ovf", {63'h0, overflow}, 64'h1);
    chk("t2_ovf_level", {60'h0, level}, 64'h8);
    for (int k = 1; k <= 8; k++) begin
      e = {32'(2 * k), 32'(2 * k - 1)};
      chk("t2_drain", out_data, e);
      idle(1'b1);
    end
    chk("t2_empty", {63'h0, out_valid}, 64'h0);
    chk("t2_ovf_sticky", {63'h0, overflow}, 64'h1);

    // 3: push into a full FIFO while popping
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 16; i++) sample(32'(100 + i), 1'b0);
    sample(32'd201, 1'b0);
    chk("t3_head", out_data, {32'd102, 32'd101});
    sample(32'd202, 1'b1);
    chk("t3_level", {60'h0, level}, 64'h8);
    chk("t3_ovf", {63'h0, overflow}, 64'h0);
    chk("t3_next", out_data, {32'd104, 32'd103});
    for (int k = 0; k < 7; k++) idle(1'b1);
    chk("t3_tail", out_data, {32'd202, 32'd201});
    idle(1'b1);

    // 4: flush discards a half pair and that cycle's sample
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    sample(32'hAA, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hBB, 1'b1);
    sample(32'hCC, 1'b0);
    sample(32'hDD, 1'b0);
    chk("t4_data", out_data, 64'h000000DD_000000CC);
    chk("t4_level", {60'h0, level}, 64'h1);
    idle(1'b1);
    chk("t4_empty", {63'h0, out_valid}, 64'h0);

    // 5: reset mid-pair with words stored
    for (int i = 0; i < 7; i++) sample(32'(300 + i), 1'b0);
    chk("t5_level3", {60'h0, level}, 64'h3);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_valid", {63'h0, out_valid}, 64'h0);
    chk("t5_level", {60'h0, level}, 64'h0);
    chk("t5_ovf", {63'h0, overflow}, 64'h0);
    sample(32'h5, 1'b0);
    sample(32'h6, 1'b0);
    chk("t5_pair", out_data, {32'h6, 32'h5});

    // 6: random stream with random back-pressure
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) sample($urandom, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 30; i++) idle($urandom_range(0, 1) == 1);
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("t6_empty", {63'h0, out_valid}, 64'h0);

    // 7: fully random mix including flush
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
